// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and rotation helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Rotate an 8-bit vector left by amt positions (bits leaving the top re-enter at bit 0).
    function automatic logic [N_REQ-1:0] rotl8(input logic [N_REQ-1:0] v, input logic [IDX_W-1:0] amt);
        logic [2*N_REQ-1:0] w_dbl;
        w_dbl = {v, v} << amt;
        return w_dbl[2*N_REQ-1:N_REQ];
    endfunction

endpackage

// File: rtl/prio_enc8_3.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins, any flags a non-zero input.
module prio_enc8_3
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] v,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign any = |v;

    // Scan from the top down so the lowest set bit is the last to overwrite idx.
    always_comb begin
        idx = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant held until release.
// Optional forced revocation after HOLD_MAX owned cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [7:0]       busy_cycles
);

    if (HOLD_MAX < 1) begin : g_hold_max_check
        $error("rr_arbiter8: HOLD_MAX must be at least 1");
    end

    arb_state_e       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic [7:0]       r_busy;
    logic [IDX_W-1:0] r_ptr;

    logic [IDX_W-1:0] w_shift;
    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_any;
    logic [IDX_W-1:0] w_winner;
    logic             w_owner_req;
    logic [7:0]       w_busy_inc;
    logic             w_revoke;

    // Rotating right by ptr+1 puts the requester just above the last winner at bit 0.
    assign w_shift     = r_ptr + 3'd1;
    assign w_rot       = rotl8(req, 3'd0 - w_shift);
    assign w_winner    = w_enc_idx + w_shift;
    assign w_owner_req = req[r_gnt_idx];
    assign w_busy_inc  = (r_busy == 8'hFF) ? 8'hFF : (r_busy + 8'd1);

`ifdef ARB_TIMEOUT_EN
    assign w_revoke = (int'({24'd0, r_busy}) >= HOLD_MAX);
`else
    assign w_revoke = 1'b0;
`endif

    prio_enc8_3 u_enc (
        .v   (w_rot),
        .idx (w_enc_idx),
        .any (w_any)
    );

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_busy      <= 8'd0;
            r_ptr       <= 3'd7;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= OWNED;
                        r_gnt       <= 8'h01 << w_winner;
                        r_gnt_idx   <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_busy      <= 8'd1;
                        r_ptr       <= w_winner;
                    end else begin
                        r_state     <= IDLE;
                        r_gnt       <= 8'h00;
                        r_gnt_idx   <= 3'd0;
                        r_gnt_valid <= 1'b0;
                        r_busy      <= 8'd0;
                    end
                end
                OWNED: begin
                    // Release and timeout both leave ptr on the owner, so others get first pick.
                    if (!w_owner_req || w_revoke) begin
                        r_state     <= IDLE;
                        r_gnt       <= 8'h00;
                        r_gnt_idx   <= 3'd0;
                        r_gnt_valid <= 1'b0;
                        r_busy      <= 8'd0;
                    end else begin
                        r_busy      <= w_busy_inc;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= 8'h00;
                    r_gnt_idx   <= 3'd0;
                    r_gnt_valid <= 1'b0;
                    r_busy      <= 8'd0;
                    r_ptr       <= 3'd7;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign gnt_idx     = r_gnt_idx;
    assign gnt_valid   = r_gnt_valid;
    assign busy_cycles = r_busy;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized requests against a behavioural model.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [7:0] busy_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner index (-1 when idle), last winner, cycles held.
    int m_owner = -1;
    int m_ptr   = 7;
    int m_busy  = 0;

    rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .busy_cycles (busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [7:0] r, input logic rs);
        bit timed_out;
        timed_out = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timed_out = (m_busy >= HOLD);
`endif
        if (rs) begin
            m_owner = -1; m_ptr = 7; m_busy = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (r[c] && m_owner < 0) begin
                    m_owner = c; m_ptr = c; m_busy = 1;
                end
            end
        end else if (!r[m_owner] || timed_out) begin
            m_owner = -1; m_busy = 0;
        end else begin
            m_busy = (m_busy >= 255) ? 255 : m_busy + 1;
        end
    endtask

    task automatic compare_model();
        logic [7:0] e_gnt;
        e_gnt = 8'h00;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        chk("gnt",       {24'd0, gnt},         {24'd0, e_gnt});
        chk("gnt_idx",   {29'd0, gnt_idx},     (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("gnt_valid", {31'd0, gnt_valid},   {31'd0, (m_owner >= 0)});
        chk("busy",      {24'd0, busy_cycles}, 32'(m_busy));
    endtask

    task automatic step(input logic [7:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
        compare_model();
    endtask

    initial begin
        // Reset state
        step(8'h00, 1'b1);
        chk("reset_gnt", {24'd0, gnt}, 32'h00);

        // Basic grant, release, re-arbitration from the updated pointer
        step(8'b0000_0101, 1'b0);
        chk("first_gnt", {24'd0, gnt}, 32'h01);
        step(8'b0000_0100, 1'b0);
        chk("release_gnt", {24'd0, gnt}, 32'h00);
        step(8'b0000_0100, 1'b0);
        chk("second_gnt", {24'd0, gnt}, 32'h04);
        chk("second_idx", {29'd0, gnt_idx}, 32'd2);
        step(8'h00, 1'b0);

        // All requesting, one-cycle tenures: strict rotation with idle gaps
        step(8'h00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b0);
            chk("ring_idx", {29'd0, gnt_idx}, 32'(i % 8));
            step(8'hFF & ~(8'h01 << (i % 8)), 1'b0);
            chk("ring_gap", {31'd0, gnt_valid}, 32'd0);
        end
        step(8'h00, 1'b0);

        // Pointer wrap: after 6 wins, 0 beats 6
        step(8'h40, 1'b0);
        step(8'h00, 1'b0);
        step(8'b0100_0001, 1'b0);
        chk("wrap_idx", {29'd0, gnt_idx}, 32'd0);
        step(8'h00, 1'b0);

        // Sole requester equal to ptr wins again
        step(8'h01, 1'b0);
        chk("same_again", {24'd0, gnt}, 32'h01);
        step(8'h00, 1'b0);

        // Long hold by requester 3
        for (int i = 0; i < 300; i++) step(8'h08, 1'b0);
`ifndef ARB_TIMEOUT_EN
        chk("sat_busy", {24'd0, busy_cycles}, 32'hFF);
        chk("sat_gnt",  {24'd0, gnt}, 32'h08);
`endif
        step(8'h00, 1'b0);

        // Two constant requesters: with timeout, tenures alternate
        for (int i = 0; i < 20; i++) step(8'b0001_1000, 1'b0);
        step(8'h00, 1'b0);

        // Reset mid-grant drops the grant and restarts ptr at 7
        step(8'h20, 1'b0);
        step(8'h20, 1'b0);
        step(8'h20, 1'b1);
        chk("rst_mid_gnt", {24'd0, gnt}, 32'h00);
        step(8'h00, 1'b0);
        step(8'h60, 1'b0);
        chk("post_rst_idx", {29'd0, gnt_idx}, 32'd5);
        step(8'h00, 1'b0);

        // Randomized traffic, with occasional sparse patterns and resets
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] r;
            logic       rs;
            r  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            rs = ($urandom_range(0, 63) == 0);
            step(r, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
